tank_input_ctrl: RTL and testbench

Per-player input decoder for BattleCity. It takes the NIOS-supplied USB keycode bus, which is widened here to a parametrised number of simultaneous key slots. Once per frame it produces a stable facing direction, a moving flag and single-cycle fire pulses for up to two players, with last-pressed-wins direction priority and optional fire auto-repeat. It sits between `nios_system.keycode_export` and `Game_Controller`, replacing the raw keycode decoding done inside the game logic.

---
 rtl/tank_input_pkg.sv | 23 ++
 rtl/tank_input_ctrl_if.sv | 15 +
 rtl/tank_input_ctrl_frame_tick_sync.sv | 22 ++
 rtl/tank_input_ctrl.sv | 87 ++++++++
 tb/tb_tank_input_ctrl.sv | 137 +++++++++++++
 5 files changed

// File: rtl/tank_input_pkg.sv
// tank_input_pkg: shared types, key map and helpers for the tank input decoder
package tank_input_pkg;

   localparam int MAX_SLOTS   = 6;
   localparam int MAX_PLAYERS = 2;

   typedef enum logic [2:0] {UP = 3'd0, RIGHT = 3'd1, DOWN = 3'd2, LEFT = 3'd3} dir_t;

   // Key index within a player's map: 0 up, 1 right, 2 down, 3 left, 4 fire
   localparam int K_FIRE = 4;

   // HID codes per player, indexed [player][key]
   localparam logic [MAX_PLAYERS-1:0][4:0][7:0] KEY_MAP = {
      {8'h28, 8'h50, 8'h51, 8'h4F, 8'h52},
      {8'h2C, 8'h04, 8'h16, 8'h07, 8'h1A}
   };

   // Highest-priority direction in a mask: up > right > down > left
   function automatic dir_t prio(input logic [3:0] m);
      return m[0] ? UP : m[1] ? RIGHT : m[2] ? DOWN : LEFT;
   endfunction

endpackage

// File: rtl/tank_input_ctrl_if.sv
// tank_input_ctrl_if: keycode/frame inputs and decoded per-player outputs
interface tank_input_ctrl_if #(
   parameter int SLOTS   = 2,
   parameter int PLAYERS = 2
);
   logic [8*SLOTS-1:0]   keycode;
   logic                 frame_clk;
   logic                 frame_tick;
   logic [3*PLAYERS-1:0] dir;
   logic [PLAYERS-1:0]   moving;
   logic [PLAYERS-1:0]   fire;

   modport master (output keycode, frame_clk, input frame_tick, dir, moving, fire);
   modport slave  (input keycode, frame_clk, output frame_tick, dir, moving, fire);
endinterface

// File: rtl/tank_input_ctrl_frame_tick_sync.sv
// frame_tick_sync: 2-flop synchroniser and rising-edge detect for frame_clk
module frame_tick_sync (
   input  logic Clk,
   input  logic Reset_n,
   input  logic frame_clk_i,
   output logic frame_tick_o
);
   logic [2:0] sync_q;
   logic       tick_q;

   // Shift frame_clk through the synchroniser; register the rising-edge pulse
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) begin
         sync_q <= '0;
         tick_q <= 1'b0;
      end else begin
         sync_q <= {sync_q[1:0], frame_clk_i};
         tick_q <= sync_q[1] & ~sync_q[2];
      end

   assign frame_tick_o = tick_q;
endmodule

// File: rtl/tank_input_ctrl.sv
// tank_input_ctrl: per-frame keycode decode to direction/moving/fire per player; TANK_FIRE_REPEAT_EN enables fire auto-repeat
module tank_input_ctrl
   import tank_input_pkg::*;
#(
   parameter int SLOTS       = 2,
   parameter int PLAYERS     = 2,
   parameter int FIRE_REPEAT = 15
) (
   input logic                Clk,
   input logic                Reset_n,
   tank_input_ctrl_if.slave   bus
);
   logic                 tick;
   logic [8*SLOTS-1:0]   key_q;

   frame_tick_sync u_sync (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .frame_clk_i  (bus.frame_clk),
      .frame_tick_o (tick)
   );

   assign bus.frame_tick = tick;

   // Sample the keycode bus every cycle
   always_ff @(posedge Clk or negedge Reset_n)
      if (!Reset_n) key_q <= '0;
      else          key_q <= bus.keycode;

   for (genvar p = 0; p < PLAYERS; p++) begin : g_player
      logic [4:0] held;
      logic [3:0] held_dir, prev_q, new_press;
      logic       fire_prev_q, fire_q, moving_q, fire_d;
      dir_t       dir_q, dir_d;

      // A key is held when any slot carries its code
      always_comb begin
         held = '0;
         for (int s = 0; s < SLOTS; s++)
            for (int k = 0; k < 5; k++)
               if (key_q[8*s +: 8] == KEY_MAP[p][k]) held[k] = 1'b1;
      end

      assign held_dir  = held[3:0];
      assign new_press = held_dir & ~prev_q;
      assign dir_d     = |new_press ? prio(new_press) :
                         held_dir[dir_q[1:0]] ? dir_q :
                         |held_dir ? prio(held_dir) : dir_q;

`ifdef TANK_FIRE_REPEAT_EN
      localparam int CW = $clog2(FIRE_REPEAT + 1);
      logic [CW-1:0] cnt_q, cnt_d;

      assign fire_d = held[K_FIRE] & (~fire_prev_q | (cnt_q <= CW'(1)));
      assign cnt_d  = !held[K_FIRE] ? '0 : fire_d ? CW'(FIRE_REPEAT) : cnt_q - 1'b1;

      // Repeat counter advances once per frame while fire is held
      always_ff @(posedge Clk or negedge Reset_n)
         if (!Reset_n)  cnt_q <= '0;
         else if (tick) cnt_q <= cnt_d;
`else
      assign fire_d = held[K_FIRE] & ~fire_prev_q;
`endif

      // Frame-rate state update; fire is a one-cycle pulse after the tick
      always_ff @(posedge Clk or negedge Reset_n)
         if (!Reset_n) begin
            prev_q      <= '0;
            fire_prev_q <= 1'b0;
            dir_q       <= UP;
            moving_q    <= 1'b0;
            fire_q      <= 1'b0;
         end else begin
            fire_q <= tick & fire_d;
            if (tick) begin
               prev_q      <= held_dir;
               fire_prev_q <= held[K_FIRE];
               dir_q       <= dir_d;
               moving_q    <= |held_dir;
            end
         end

      assign bus.dir[3*p +: 3] = dir_q;
      assign bus.moving[p]     = moving_q;
      assign bus.fire[p]       = fire_q;
   end
endmodule

// File: tb/tb_tank_input_ctrl.sv
// tb_tank_input_ctrl: directed frames with a scoreboard of expected per-frame outputs
module tb_tank_input_ctrl;
   logic Clk = 1'b0;
   logic Reset_n = 1'b0;

   tank_input_ctrl_if #(.SLOTS(2), .PLAYERS(2)) bus ();

   tank_input_ctrl #(.SLOTS(2), .PLAYERS(2), .FIRE_REPEAT(3)) dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .bus     (bus)
   );

   always #5 Clk = ~Clk;

   typedef struct {
      logic [5:0] dir;
      logic [1:0] mov;
      logic [1:0] fire;
   } exp_t;

   exp_t sb[$];
   int   n_chk = 0;
   int   n_fail = 0;

`ifdef TANK_FIRE_REPEAT_EN
   localparam bit REP = 1'b1;
`else
   localparam bit REP = 1'b0;
`endif

   function automatic exp_t mk(input logic [5:0] d, input logic [1:0] m, input logic [1:0] f);
      exp_t e;
      e.dir = d;
      e.mov = m;
      e.fire = f;
      return e;
   endfunction

   task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic frame(input logic [15:0] kc, input exp_t e);
      logic got;
      int   lat;
      exp_t x;
      @(negedge Clk);
      bus.keycode = kc;
      repeat (2) @(negedge Clk);
      sb.push_back(e);
      bus.frame_clk = 1'b1;
      got = 1'b0;
      lat = 0;
      for (int i = 0; i < 8 && !got; i++) begin
         @(negedge Clk);
         lat++;
         got = bus.frame_tick;
      end
      check("tick_seen", {7'd0, got}, 8'd1);
      x = sb.pop_front();
      if (got) begin
         check("tick_latency", 8'(lat), 8'd3);
         @(negedge Clk);
         check("tick_width", {7'd0, bus.frame_tick}, 8'd0);
         check("dir", {2'd0, bus.dir}, {2'd0, x.dir});
         check("moving", {6'd0, bus.moving}, {6'd0, x.mov});
         check("fire", {6'd0, bus.fire}, {6'd0, x.fire});
         @(negedge Clk);
         check("fire_width", {6'd0, bus.fire}, 8'd0);
      end
      bus.frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
   endtask

   initial begin
      bus.keycode = '0;
      bus.frame_clk = 1'b0;
      repeat (3) @(negedge Clk);
      check("rst_dir", {2'd0, bus.dir}, 8'd0);
      check("rst_moving", {6'd0, bus.moving}, 8'd0);
      check("rst_fire", {6'd0, bus.fire}, 8'd0);
      check("rst_tick", {7'd0, bus.frame_tick}, 8'd0);
      Reset_n = 1'b1;
      // Hold W, then release
      frame(16'h001A, mk(6'o00, 2'b01, 2'b00));
      frame(16'h001A, mk(6'o00, 2'b01, 2'b00));
      frame(16'h0000, mk(6'o00, 2'b00, 2'b00));
      // A, then A+D, then D released
      frame(16'h0004, mk(6'o03, 2'b01, 2'b00));
      frame(16'h0704, mk(6'o01, 2'b01, 2'b00));
      frame(16'h0004, mk(6'o03, 2'b01, 2'b00));
      frame(16'h0000, mk(6'o03, 2'b00, 2'b00));
      // W and D together from idle
      frame(16'h071A, mk(6'o00, 2'b01, 2'b00));
      // A press that comes and goes between ticks is not seen
      @(negedge Clk);
      bus.keycode = 16'h0016;
      repeat (3) @(negedge Clk);
      bus.keycode = 16'h0000;
      frame(16'h0000, mk(6'o00, 2'b00, 2'b00));
      // Both players fire together
      frame(16'h282C, mk(6'o00, 2'b00, 2'b11));
      frame(16'h0000, mk(6'o00, 2'b00, 2'b00));
      // Player independence
      frame(16'h0016, mk(6'o02, 2'b01, 2'b00));
      frame(16'h5000, mk(6'o32, 2'b10, 2'b00));
      frame(16'h0052, mk(6'o02, 2'b10, 2'b00));
      frame(16'h0000, mk(6'o02, 2'b00, 2'b00));
      // Hold Space for 10 frames
      for (int i = 0; i < 10; i++)
         frame(16'h002C, mk(6'o02, 2'b00, {1'b0, REP ? (i % 3 == 0) : (i == 0)}));
      frame(16'h0000, mk(6'o02, 2'b00, 2'b00));
      // Unmapped codes, duplicate slots
      frame(16'h1B05, mk(6'o02, 2'b00, 2'b00));
      frame(16'h0707, mk(6'o01, 2'b01, 2'b00));
      frame(16'h2C07, mk(6'o01, 2'b01, 2'b01));
      // Asynchronous reset mid-frame with keys held
      @(negedge Clk);
      #2 Reset_n = 1'b0;
      #1;
      check("arst_dir", {2'd0, bus.dir}, 8'd0);
      check("arst_moving", {6'd0, bus.moving}, 8'd0);
      check("arst_fire", {6'd0, bus.fire}, 8'd0);
      check("arst_tick", {7'd0, bus.frame_tick}, 8'd0);
      @(negedge Clk);
      Reset_n = 1'b1;
      frame(16'h2C07, mk(6'o01, 2'b01, 2'b01));
      frame(16'h0000, mk(6'o01, 2'b00, 2'b00));
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
